// File: rtl/ps2_voice_allocator.sv
// Polyphonic voice allocator: parses PS/2 make/break/extended bytes and
// maps held musical keys onto NUM_VOICES tone generators, stealing the oldest.
// Ports: sys_clk, reset (async, active-low), scan_valid/scan_byte (byte strobe),
//   all_off (panic), voice_on, voice_code (8 bits per voice), voice_trig, steal.
module ps2_voice_allocator #(
  parameter int NUM_VOICES  = 4,
  parameter int AGE_W       = 4,
  parameter int TIMEOUT_CYC = 50000
) (
  input  logic                    sys_clk,
  input  logic                    reset,
  input  logic                    scan_valid,
  input  logic [7:0]              scan_byte,
  input  logic                    all_off,
  output logic [NUM_VOICES-1:0]   voice_on,
  output logic [8*NUM_VOICES-1:0] voice_code,
  output logic [NUM_VOICES-1:0]   voice_trig,
  output logic                    steal
);

  localparam int IW = $clog2(NUM_VOICES);
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [AGE_W-1:0] AGE_MAX = '1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);

  typedef enum logic [1:0] {
    IDLE,
    BRK,
    EXT,
    EXT_BRK
  } state_t;

  state_t state_q, state_d;
  logic [TW-1:0] tmo_q;
  logic tmo_expire;

  logic [7:0]       code_q [NUM_VOICES];
  logic [AGE_W-1:0] age_q  [NUM_VOICES];

  logic do_make, do_rel;
  logic hit, free_any;
  logic [IW-1:0] free_idx, old_idx, sel_idx;
  logic [AGE_W-1:0] old_age;

  function automatic logic is_musical(input logic [7:0] b);
    unique case (b)
      8'h15, 8'h1D, 8'h1C, 8'h1B, 8'h24,
      8'h23, 8'h2B, 8'h2C, 8'h34, 8'h35,
      8'h33, 8'h3B, 8'h43, 8'h42, 8'h44,
      8'h4B, 8'h4D, 8'h4C, 8'h52, 8'h5B:
        is_musical = 1'b1;
      default:
        is_musical = 1'b0;
    endcase
  endfunction

  // State register and prefix timeout counter
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      tmo_q   <= '0;
    end else begin
      state_q <= state_d;
      if (all_off || scan_valid || state_q == IDLE || tmo_expire)
        tmo_q <= '0;
      else
        tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_expire = (state_q != IDLE) && !scan_valid
                      && (tmo_q == TMO_LAST);

  // Next-state logic
  always_comb begin
    state_d = state_q;
    if (all_off) begin
      state_d = IDLE;
    end else if (scan_valid) begin
      unique case (state_q)
        IDLE: begin
          unique case (1'b1)
            scan_byte == 8'hF0: state_d = BRK;
            scan_byte == 8'hE0: state_d = EXT;
            default:            state_d = IDLE;
          endcase
        end
        EXT:     state_d = (scan_byte == 8'hF0) ? EXT_BRK : IDLE;
        BRK:     state_d = IDLE;
        EXT_BRK: state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end else if (tmo_expire) begin
      state_d = IDLE;
    end
  end

  // Action decode
  always_comb begin
    do_make = 1'b0;
    do_rel  = 1'b0;
    if (!all_off && scan_valid) begin
      do_make = (state_q == IDLE) && is_musical(scan_byte);
      do_rel  = (state_q == BRK);
    end
  end

  // Voice selection: repeat hit, lowest free, else oldest (ties low)
  always_comb begin
    hit      = 1'b0;
    free_any = 1'b0;
    free_idx = '0;
    old_idx  = '0;
    old_age  = age_q[0];
    for (int i = 0; i < NUM_VOICES; i++)
      if (voice_on[i] && code_q[i] == scan_byte)
        hit = 1'b1;
    for (int i = NUM_VOICES - 1; i >= 0; i--)
      if (!voice_on[i]) begin
        free_any = 1'b1;
        free_idx = IW'(i);
      end
    for (int i = 1; i < NUM_VOICES; i++)
      if (age_q[i] > old_age) begin
        old_age = age_q[i];
        old_idx = IW'(i);
      end
    sel_idx = free_any ? free_idx : old_idx;
  end

  // Voice state
  always_ff @(posedge sys_clk or negedge reset) begin
    if (!reset) begin
      voice_on   <= '0;
      voice_trig <= '0;
      steal      <= 1'b0;
      for (int i = 0; i < NUM_VOICES; i++) begin
        code_q[i] <= 8'hF0;
        age_q[i]  <= '0;
      end
    end else begin
      voice_trig <= '0;
      steal      <= 1'b0;
      if (all_off) begin
        voice_on <= '0;
        for (int i = 0; i < NUM_VOICES; i++) begin
          code_q[i] <= 8'hF0;
          age_q[i]  <= '0;
        end
      end else if (do_make && !hit) begin
        steal <= !free_any;
        for (int i = 0; i < NUM_VOICES; i++) begin
          if (i == int'(sel_idx)) begin
            voice_on[i]   <= 1'b1;
            voice_trig[i] <= 1'b1;
            code_q[i]     <= scan_byte;
            age_q[i]      <= '0;
          end else if (voice_on[i] && age_q[i] != AGE_MAX) begin
            age_q[i] <= age_q[i] + 1'b1;
          end
        end
      end else if (do_rel) begin
        for (int i = 0; i < NUM_VOICES; i++)
          if (code_q[i] == scan_byte) begin
            voice_on[i] <= 1'b0;
            code_q[i]   <= 8'hF0;
          end
      end
    end
  end

  for (genvar g = 0; g < NUM_VOICES; g++) begin : g_code
    assign voice_code[8*g +: 8] = code_q[g];
  end

endmodule

// File: tb/tb_ps2_voice_allocator.sv
// Directed bench for ps2_voice_allocator (4 voices, short prefix timeout).
// Table of byte vectors with expected outputs plus timeout/reset sequences.
module tb_ps2_voice_allocator;

  localparam int NV  = 4;
  localparam int TMO = 20;

  logic        sys_clk = 1'b0;
  logic        reset;
  logic        scan_valid;
  logic [7:0]  scan_byte;
  logic        all_off;
  logic [NV-1:0]   voice_on;
  logic [8*NV-1:0] voice_code;
  logic [NV-1:0]   voice_trig;
  logic            steal;

  int n_vec = 0;
  int n_err = 0;

  ps2_voice_allocator #(
    .NUM_VOICES(NV),
    .AGE_W(4),
    .TIMEOUT_CYC(TMO)
  ) dut (
    .sys_clk(sys_clk),
    .reset(reset),
    .scan_valid(scan_valid),
    .scan_byte(scan_byte),
    .all_off(all_off),
    .voice_on(voice_on),
    .voice_code(voice_code),
    .voice_trig(voice_trig),
    .steal(steal)
  );

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    string       name;
    logic        ao;
    logic        v;
    logic [7:0]  b;
    logic [3:0]  on;
    logic [31:0] code;
    logic [3:0]  tr;
    logic        st;
  } vec_t;

  vec_t tbl[$];

  function automatic void add(string n, logic ao, logic v,
                              logic [7:0] b, logic [3:0] on,
                              logic [31:0] code, logic [3:0] tr,
                              logic st);
    vec_t r;
    r.name = n; r.ao = ao; r.v = v; r.b = b;
    r.on = on; r.code = code; r.tr = tr; r.st = st;
    tbl.push_back(r);
  endfunction

  task automatic step(input logic ao, input logic v,
                      input logic [7:0] b);
    @(negedge sys_clk);
    all_off    = ao;
    scan_valid = v;
    scan_byte  = b;
    @(posedge sys_clk);
    #1;
  endtask

  task automatic check(input string n, input logic [3:0] on,
                       input logic [31:0] code, input logic [3:0] tr,
                       input logic st);
    n_vec++;
    if (voice_on !== on || voice_code !== code
        || voice_trig !== tr || steal !== st) begin
      n_err++;
      $display("FAIL %s: got on=%b code=%h trig=%b steal=%b, want on=%b code=%h trig=%b steal=%b",
               n, voice_on, voice_code, voice_trig, steal,
               on, code, tr, st);
    end
  endtask

  initial begin
    reset = 1'b0; scan_valid = 1'b0; scan_byte = 8'h00; all_off = 1'b0;
    repeat (3) @(posedge sys_clk);
    #1;
    check("reset", 4'b0000, 32'hF0F0F0F0, 4'b0000, 1'b0);
    @(negedge sys_clk);
    reset = 1'b1;

    // allocation in order
    add("mk1C",   0, 1, 8'h1C, 4'b0001, 32'hF0F0F01C, 4'b0001, 0);
    add("mk1B",   0, 1, 8'h1B, 4'b0011, 32'hF0F01B1C, 4'b0010, 0);
    add("mk23",   0, 1, 8'h23, 4'b0111, 32'hF0231B1C, 4'b0100, 0);
    add("idle1",  0, 0, 8'h00, 4'b0111, 32'hF0231B1C, 4'b0000, 0);
    // typematic repeat and release
    add("rep1",   0, 1, 8'h1C, 4'b0111, 32'hF0231B1C, 4'b0000, 0);
    add("rep2",   0, 1, 8'h1C, 4'b0111, 32'hF0231B1C, 4'b0000, 0);
    add("brkF0",  0, 1, 8'hF0, 4'b0111, 32'hF0231B1C, 4'b0000, 0);
    add("brk1C",  0, 1, 8'h1C, 4'b0110, 32'hF0231BF0, 4'b0000, 0);
    // fill and steal oldest
    add("mk15",   0, 1, 8'h15, 4'b0111, 32'hF0231B15, 4'b0001, 0);
    add("mk1D",   0, 1, 8'h1D, 4'b1111, 32'h1D231B15, 4'b1000, 0);
    add("stl1C",  0, 1, 8'h1C, 4'b1111, 32'h1D231C15, 4'b0010, 1);
    add("stl1B",  0, 1, 8'h1B, 4'b1111, 32'h1D1B1C15, 4'b0100, 1);
    add("stl24",  0, 1, 8'h24, 4'b1111, 32'h1D1B1C24, 4'b0001, 1);
    add("idle2",  0, 0, 8'h00, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    // extended keys and non-musical codes
    add("xE0a",   0, 1, 8'hE0, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("x15",    0, 1, 8'h15, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("xE0b",   0, 1, 8'hE0, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("xF0",    0, 1, 8'hF0, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("x1C",    0, 1, 8'h1C, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("nm75",   0, 1, 8'h75, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("nhF0",   0, 1, 8'hF0, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    add("nh44",   0, 1, 8'h44, 4'b1111, 32'h1D1B1C24, 4'b0000, 0);
    // panic beats a simultaneous byte and clears a pending break
    add("aoff23", 1, 1, 8'h23, 4'b0000, 32'hF0F0F0F0, 4'b0000, 0);
    add("pF0",    0, 1, 8'hF0, 4'b0000, 32'hF0F0F0F0, 4'b0000, 0);
    add("aoff",   1, 0, 8'h00, 4'b0000, 32'hF0F0F0F0, 4'b0000, 0);
    add("pmk1C",  0, 1, 8'h1C, 4'b0001, 32'hF0F0F01C, 4'b0001, 0);

    foreach (tbl[k]) begin
      step(tbl[k].ao, tbl[k].v, tbl[k].b);
      check(tbl[k].name, tbl[k].on, tbl[k].code, tbl[k].tr, tbl[k].st);
    end

    // break just inside the timeout still releases
    step(0, 1, 8'hF0);
    repeat (TMO - 1) step(0, 0, 8'h00);
    step(0, 1, 8'h1C);
    check("tmo_in", 4'b0000, 32'hF0F0F0F0, 4'b0000, 1'b0);

    // break that waited the full timeout turns into a make
    step(0, 1, 8'hF0);
    repeat (TMO) step(0, 0, 8'h00);
    step(0, 1, 8'h1C);
    check("tmo_out", 4'b0001, 32'hF0F0F01C, 4'b0001, 1'b0);

    // reset between F0 and the key forgets the break
    step(0, 1, 8'hF0);
    @(negedge sys_clk);
    scan_valid = 1'b0;
    reset = 1'b0;
    #2;
    check("rst_mid", 4'b0000, 32'hF0F0F0F0, 4'b0000, 1'b0);
    @(negedge sys_clk);
    reset = 1'b1;
    step(0, 1, 8'h1C);
    check("rst_mk", 4'b0001, 32'hF0F0F01C, 4'b0001, 1'b0);
    step(0, 0, 8'h00);
    check("trig_1cyc", 4'b0001, 32'hF0F0F01C, 4'b0000, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
